// File: rtl/conv553_seq.sv
// conv553_seq
// Sequences one conv553 datapath over a full 3-channel input map and produces
// one output channel of a valid (no-padding) KxK convolution.
//
// Each RUN cycle without hold issues one column read: a K-row strip whose top
// row is rd_row, at column rd_col. Channels are read in parallel. conv_en
// follows rd_en one cycle later to match the memory read latency. A tag for
// each read travels alongside the data and marks which reads complete an
// output pixel (out_valid, out_row, out_col).
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous reset, active-high
//   start      single-cycle pulse that begins a map pass (accepted in IDLE only)
//   hold       stall request; suppresses new reads only
//   busy       pass in progress
//   done       single-cycle pulse, coincident with the final out_valid
//   rd_en      column read strobe to memory
//   rd_row     top row of the K-row strip
//   rd_col     column index
//   conv_en    datapath enable; shifts one column into all three windows
//   out_valid  convValue is a complete output pixel this cycle
//   out_row    output pixel row (0 when out_valid is low)
//   out_col    output pixel column (0 when out_valid is low)
//
// Handshake: there is no back-pressure from memory or datapath. A read is
// issued in every cycle where rd_en is high; conv_en is high exactly one cycle
// after each read; out_valid is a one-cycle strobe with no acknowledge.
module conv553_seq #(
    parameter int IN_W     = 32,
    parameter int IN_H     = 32,
    parameter int K        = 5,
    parameter int CONV_LAT = 1,
    parameter int CNT_W    = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    output logic             busy,
    output logic             done,
    output logic             rd_en,
    output logic [CNT_W-1:0] rd_row,
    output logic [CNT_W-1:0] rd_col,
    output logic             conv_en,
    output logic             out_valid,
    output logic [CNT_W-1:0] out_row,
    output logic [CNT_W-1:0] out_col
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    // Tag delay: one cycle of memory latency plus the datapath latency.
    localparam int DLY = 1 + CONV_LAT;

    localparam logic [CNT_W-1:0] COL_LAST     = CNT_W'(IN_W - 1);
    localparam logic [CNT_W-1:0] ROW_LAST     = CNT_W'(IN_H - K);
    localparam logic [CNT_W-1:0] OUT_COL_LAST = CNT_W'(IN_W - K);
    localparam logic [CNT_W-1:0] KM1          = CNT_W'(K - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] row;
    logic [CNT_W-1:0] col;
    logic             last_tag;
    logic             tag_valid;
    logic [CNT_W-1:0] tag_row;
    logic [CNT_W-1:0] tag_col;

    logic             tv_q [DLY];
    logic [CNT_W-1:0] tr_q [DLY];
    logic [CNT_W-1:0] tc_q [DLY];

    assign busy      = (state != IDLE);
    assign rd_row    = row;
    assign rd_col    = col;
    assign out_valid = tv_q[DLY-1];
    assign out_row   = tr_q[DLY-1];
    assign out_col   = tc_q[DLY-1];

    // The final output pixel of the pass is the bottom-right one.
    assign last_tag = out_valid && (out_row == ROW_LAST) && (out_col == OUT_COL_LAST);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and strobes. rd_en is decoded from the state register and
    // hold so that a stall takes effect in the very cycle hold is raised.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                rd_en = !hold;
                if (!hold && (col == COL_LAST) && (row == ROW_LAST)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (last_tag) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strip position counters; they only move on an issued read and return
    // to 0 after the final read so the next pass starts clean.
    always_ff @(posedge clk) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (rd_en) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + CNT_W'(1);
            end else begin
                col <= col + CNT_W'(1);
            end
        end
    end

    // Data for a read arrives one cycle later; the datapath is enabled then.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_en <= 1'b0;
        end else begin
            conv_en <= rd_en;
        end
    end

    // A read completes a window once K columns of the current row have been
    // shifted in. Coordinates of non-completing reads are forced to 0 so the
    // outputs never show out-of-range values.
    assign tag_valid = rd_en && (col >= KM1);
    assign tag_row   = tag_valid ? row : '0;
    assign tag_col   = tag_valid ? (col - KM1) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DLY; i++) begin
                tv_q[i] <= 1'b0;
                tr_q[i] <= '0;
                tc_q[i] <= '0;
            end
        end else begin
            tv_q[0] <= tag_valid;
            tr_q[0] <= tag_row;
            tc_q[0] <= tag_col;
            for (int i = 1; i < DLY; i++) begin
                tv_q[i] <= tv_q[i-1];
                tr_q[i] <= tr_q[i-1];
                tc_q[i] <= tc_q[i-1];
            end
        end
    end

endmodule

// File: tb/tb_conv553_seq.sv
// Bench for conv553_seq: default 32x32/K=5/CONV_LAT=1 instance plus a small
// 8x8/K=5/CONV_LAT=3 instance. Expected reads and outputs (coordinates and
// cycle of arrival) are queued when a start is issued and popped by monitors.
module tb_conv553_seq;

    localparam int W   = 32;
    localparam int H   = 32;
    localparam int KK  = 5;
    localparam int LAT = 1;
    localparam int CW  = 6;

    logic clk = 1'b0;
    logic rst, start, hold, start2, hold2;

    logic          busy, done, rd_en, conv_en, out_valid;
    logic [CW-1:0] rd_row, rd_col, out_row, out_col;

    logic          busy2, done2, rd_en2, conv_en2, out_valid2;
    logic [CW-1:0] rd_row2, rd_col2, out_row2, out_col2;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    conv553_seq #(.IN_W(W), .IN_H(H), .K(KK), .CONV_LAT(LAT), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .busy(busy), .done(done), .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col),
        .conv_en(conv_en), .out_valid(out_valid), .out_row(out_row), .out_col(out_col)
    );

    conv553_seq #(.IN_W(8), .IN_H(8), .K(5), .CONV_LAT(3), .CNT_W(CW)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .hold(hold2),
        .busy(busy2), .done(done2), .rd_en(rd_en2), .rd_row(rd_row2), .rd_col(rd_col2),
        .conv_en(conv_en2), .out_valid(out_valid2), .out_row(out_row2), .out_col(out_col2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard state.
    logic [2*CW-1:0] exp_q[$];
    int              exp_t_q[$];
    logic [2*CW-1:0] rd_q[$];
    int              rd_t_q[$];
    int              done_cyc = -1;
    int              busy_lo  = -1;
    int              busy_hi  = -2;
    int              n_out    = 0;
    logic            prev_rd  = 1'b0;

    logic [2*CW-1:0] exp2_q[$];
    int              exp2_t_q[$];
    int              done2_cyc = -1;
    int              n_out2    = 0;
    int              n_rd2     = 0;

    // Reference schedule for one pass of the default instance. Start is driven
    // in cycle s; reads run from s+1 in raster order, skipping hold cycles.
    task automatic push_pass(input int s, input int hlo, input int hhi);
        int c;
        c = s + 1;
        for (int r = 0; r <= H - KK; r++) begin
            for (int cl = 0; cl < W; cl++) begin
                while (c >= hlo && c <= hhi) c++;
                rd_q.push_back({CW'(r), CW'(cl)});
                rd_t_q.push_back(c);
                if (cl >= KK - 1) begin
                    exp_q.push_back({CW'(r), CW'(cl - (KK - 1))});
                    exp_t_q.push_back(c + 1 + LAT);
                    done_cyc = c + 1 + LAT;
                end
                c++;
            end
        end
        busy_lo = s + 1;
        busy_hi = done_cyc;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_rd_en"}, rd_en, 0);
        check({tag, "_conv_en"}, conv_en, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_rd_pos"}, {rd_row, rd_col}, 0);
        check({tag, "_out_pos"}, {out_row, out_col}, 0);
    endtask

    // Monitor for the default instance.
    always begin
        logic [2*CW-1:0] v;
        int              t;
        @(negedge clk);
        #2;
        check("busy", busy, (busy_lo >= 0 && cyc >= busy_lo && cyc <= busy_hi));
        check("conv_en", conv_en, prev_rd);
        prev_rd = rd_en && !rst;
        check("done", done, out_valid && (cyc == done_cyc));
        if (rd_en) begin
            if (rd_q.size() == 0) begin
                check("rd_unexpected", rd_en, 0);
            end else begin
                v = rd_q.pop_front();
                t = rd_t_q.pop_front();
                check("rd_cycle", cyc, t);
                check("rd_row", rd_row, v[2*CW-1:CW]);
                check("rd_col", rd_col, v[CW-1:0]);
            end
        end
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected", out_valid, 0);
            end else begin
                v = exp_q.pop_front();
                t = exp_t_q.pop_front();
                n_out++;
                check("out_cycle", cyc, t);
                check("out_row", out_row, v[2*CW-1:CW]);
                check("out_col", out_col, v[CW-1:0]);
            end
        end
    end

    // Monitor for the small instance.
    always begin
        logic [2*CW-1:0] v;
        int              t;
        @(negedge clk);
        #2;
        check("done2", done2, out_valid2 && (cyc == done2_cyc));
        if (rd_en2) n_rd2++;
        if (out_valid2) begin
            if (exp2_q.size() == 0) begin
                check("out2_unexpected", out_valid2, 0);
            end else begin
                v = exp2_q.pop_front();
                t = exp2_t_q.pop_front();
                n_out2++;
                check("out2_cycle", cyc, t);
                check("out2_pos", {out_row2, out_col2}, v);
            end
        end
    end

    initial begin
        int sa, sb, sc, sd;
        rst    = 1'b1;
        start  = 1'b0;
        hold   = 1'b0;
        start2 = 1'b0;
        hold2  = 1'b0;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        check("reset_busy2", busy2, 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pass A: nominal, plus starts while busy and in the done cycle.
        sa = cyc;
        push_pass(sa, -1, -1);
        n_out = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(sa + 100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(done_cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(sa + 900);
        check("passA_outputs", n_out, 784);
        check("passA_left", exp_q.size() + rd_q.size(), 0);

        // Pass B: hold for five cycles early in the pass.
        sb = cyc;
        push_pass(sb, sb + 10, sb + 14);
        n_out = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(sb + 10);
        hold = 1'b1;
        wait_cyc(sb + 15);
        hold = 1'b0;
        wait_cyc(done_cyc + 3);
        check("passB_outputs", n_out, 784);
        check("passB_left", exp_q.size() + rd_q.size(), 0);

        // Pass C: reset mid-pass, then restart.
        sc = cyc;
        push_pass(sc, -1, -1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(sc + 300);
        rst = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        exp_t_q.delete();
        rd_q.delete();
        rd_t_q.delete();
        busy_hi  = sc + 300;
        done_cyc = -1;
        @(negedge clk);
        check_idle_outputs("midreset");
        rst = 1'b0;
        wait_cyc(sc + 310);
        push_pass(sc + 310, -1, -1);
        n_out = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_cyc(done_cyc + 3);
        check("passC_outputs", n_out, 784);
        check("passC_left", exp_q.size() + rd_q.size(), 0);

        // Pass D: small map, outputs (r,c) at sd + 9 + 8r + c.
        sd = cyc;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                exp2_q.push_back({CW'(r), CW'(c)});
                exp2_t_q.push_back(sd + 9 + 8 * r + c);
            end
        end
        done2_cyc = sd + 36;
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        wait_cyc(sd + 40);
        check("small_outputs", n_out2, 16);
        check("small_reads", n_rd2, 32);
        check("small_busy_end", busy2, 0);
        check("small_left", exp2_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
